// File: rtl/rf_alu_pipe.sv
// Register file plus ALU datapath with a one-stage registered write-back, read forwarding
// from that stage, an NZCV flag register feeding ADC/SBB, and a bit-serial shifter that
// stalls issue while it runs.
module rf_alu_pipe #(
  parameter int unsigned DW   = 16,
  parameter int unsigned NREG = 8,
  parameter int unsigned AW   = $clog2(NREG),
  parameter int unsigned IMMW = 5
) (
  input  logic            CLK,
  input  logic            CLR,
  input  logic            issue,
  input  logic [2:0]      ALUctrl,
  input  logic            ALUsrc,
  input  logic [2:0]      wb_sel,
  input  logic            WE,
  input  logic [AW-1:0]   RdAddr,
  input  logic [AW-1:0]   RnAddr,
  input  logic [AW-1:0]   RmAddr,
  input  logic            S_Rn_or_Rd,
  input  logic [IMMW-1:0] imm5,
  input  logic [7:0]      imm8,
  input  logic [DW-1:0]   Memory_data,
  input  logic [DW-1:0]   PC_data,
  output logic [DW-1:0]   RD1,
  output logic [DW-1:0]   RD2,
  output logic [DW-1:0]   Result,
  output logic            C,
  output logic            V,
  output logic            N,
  output logic            Z,
  output logic            busy,
  output logic            done
);

  localparam int unsigned SW = $clog2(DW);

  // Architectural state
  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic [AW-1:0] wb_addr_q, wb_addr_d;
  logic          wb_valid_q, wb_valid_d;
  logic          c_q, c_d, v_q, v_d, n_q, n_d, z_q, z_d;

  // Shifter state, latched at accept
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] sh_data_q, sh_data_d;
  logic [SW-1:0] sh_cnt_q, sh_cnt_d;
  logic          sh_zero_q, sh_zero_d;
  logic          sh_dir_q, sh_dir_d;
  logic [AW-1:0] sh_addr_q, sh_addr_d;
  logic          sh_we_q, sh_we_d;

  // Datapath signals
  logic [DW-1:0] rn_val, rm_val, rd_val, op_b, b_eff;
  logic [DW:0]   sum;
  logic          cin, arith_v, is_shift;
  logic [SW-1:0] amt;
  logic [DW-1:0] sh_step, lhi_val, op_res;
  logic          sh_out, op_load, op_nz, op_cv;

  // Forwarded reads: the pending write-back value wins over the stale register contents
  always_comb begin
    rn_val = (wb_valid_q && wb_addr_q == RnAddr) ? wb_data_q : regs_q[RnAddr];
    rm_val = (wb_valid_q && wb_addr_q == RmAddr) ? wb_data_q : regs_q[RmAddr];
    rd_val = (wb_valid_q && wb_addr_q == RdAddr) ? wb_data_q : regs_q[RdAddr];
  end

  assign RD1    = rn_val;
  assign RD2    = S_Rn_or_Rd ? rd_val : rm_val;
  assign Result = wb_data_q;
  assign C      = c_q;
  assign V      = v_q;
  assign N      = n_q;
  assign Z      = z_q;
  assign busy   = busy_q;
  assign done   = done_q;

  // Operand selection, adder and shifter step
  always_comb begin
    op_b     = ALUsrc ? DW'(imm5) : rm_val;
    // Subtraction adds ~B; ADD injects 0, SUB injects 1, ADC/SBB inject the stored carry
    b_eff    = ALUctrl[1] ? ~op_b : op_b;
    cin      = ALUctrl[0] ? c_q : ALUctrl[1];
    sum      = {1'b0, rn_val} + {1'b0, b_eff} + {{DW{1'b0}}, cin};
    arith_v  = (rn_val[DW-1] == b_eff[DW-1]) && (sum[DW-1] != rn_val[DW-1]);
    is_shift = (wb_sel == 3'b000) && (ALUctrl[2:1] == 2'b11);
    amt      = op_b[SW-1:0];
    // LHI replaces the top byte and keeps the low DW-8 bits of the forwarded Rd
    lhi_val  = (DW'(imm8) << (DW - 8)) | (rd_val & ({DW{1'b1}} >> 8));
    sh_step  = sh_dir_q ? (sh_data_q >> 1) : (sh_data_q << 1);
    sh_out   = sh_dir_q ? sh_data_q[0] : sh_data_q[DW-1];
  end

  // Next-state: shifter progress, or accept of a new operation when idle
  always_comb begin
    busy_d     = busy_q;
    done_d     = 1'b0;
    sh_data_d  = sh_data_q;
    sh_cnt_d   = sh_cnt_q;
    sh_zero_d  = sh_zero_q;
    sh_dir_d   = sh_dir_q;
    sh_addr_d  = sh_addr_q;
    sh_we_d    = sh_we_q;
    wb_data_d  = wb_data_q;
    wb_addr_d  = wb_addr_q;
    wb_valid_d = 1'b0;
    c_d        = c_q;
    v_d        = v_q;
    n_d        = n_q;
    z_d        = z_q;
    op_res     = '0;
    op_load    = 1'b0;
    op_nz      = 1'b0;
    op_cv      = 1'b0;

    if (busy_q) begin
      sh_cnt_d = sh_cnt_q - 1'b1;
      if (!sh_zero_q) begin
        sh_data_d = sh_step;
      end
      if (sh_cnt_q == SW'(1)) begin
        busy_d     = 1'b0;
        done_d     = 1'b1;
        wb_data_d  = sh_data_d;
        wb_addr_d  = sh_addr_q;
        wb_valid_d = sh_we_q;
        n_d        = sh_data_d[DW-1];
        z_d        = (sh_data_d == '0);
        if (!sh_zero_q) begin
          c_d = sh_out;
        end
      end
    end else if (issue) begin
      if (is_shift) begin
        // A zero amount still occupies one busy cycle so done always follows accept
        busy_d    = 1'b1;
        sh_data_d = rn_val;
        sh_cnt_d  = (amt == '0) ? SW'(1) : amt;
        sh_zero_d = (amt == '0);
        sh_dir_d  = ALUctrl[0];
        sh_addr_d = RdAddr;
        sh_we_d   = WE;
      end else begin
        unique case (wb_sel)
          3'b000: begin
            op_load = 1'b1;
            op_nz   = 1'b1;
            case (ALUctrl)
              3'b100:  op_res = rn_val & op_b;
              3'b101:  op_res = rn_val | op_b;
              default: begin
                op_res = sum[DW-1:0];
                op_cv  = 1'b1;
              end
            endcase
          end
          3'b001: begin op_load = 1'b1; op_res = Memory_data;  end
          3'b010: begin op_load = 1'b1; op_res = PC_data;      end
          3'b011: begin op_load = 1'b1; op_res = lhi_val;      end
          3'b100: begin op_load = 1'b1; op_res = DW'(imm8);    end
          3'b101: begin op_load = 1'b1; op_res = rm_val;       end
          3'b110: begin op_load = 1'b1; op_nz = 1'b1; op_res = rn_val ^ op_b; end
          3'b111: ;
        endcase
        if (op_load) begin
          wb_data_d  = op_res;
          wb_addr_d  = RdAddr;
          wb_valid_d = WE;
        end
        if (op_nz) begin
          n_d = op_res[DW-1];
          z_d = (op_res == '0);
        end
        if (op_cv) begin
          c_d = sum[DW];
          v_d = arith_v;
        end
      end
    end
  end

  // Pipeline, flag and shifter registers
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      wb_data_q  <= '0;
      wb_addr_q  <= '0;
      wb_valid_q <= 1'b0;
      c_q        <= 1'b0;
      v_q        <= 1'b0;
      n_q        <= 1'b0;
      z_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sh_data_q  <= '0;
      sh_cnt_q   <= '0;
      sh_zero_q  <= 1'b0;
      sh_dir_q   <= 1'b0;
      sh_addr_q  <= '0;
      sh_we_q    <= 1'b0;
    end else begin
      wb_data_q  <= wb_data_d;
      wb_addr_q  <= wb_addr_d;
      wb_valid_q <= wb_valid_d;
      c_q        <= c_d;
      v_q        <= v_d;
      n_q        <= n_d;
      z_q        <= z_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sh_data_q  <= sh_data_d;
      sh_cnt_q   <= sh_cnt_d;
      sh_zero_q  <= sh_zero_d;
      sh_dir_q   <= sh_dir_d;
      sh_addr_q  <= sh_addr_d;
      sh_we_q    <= sh_we_d;
    end
  end

  // Register file commit from the write-back stage
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_valid_q) begin
      regs_q[wb_addr_q] <= wb_data_q;
    end
  end

endmodule

// File: tb/tb_rf_alu_pipe.sv
// Scoreboard bench for rf_alu_pipe: expected {Result, N, Z, C, V} pushed at issue,
// popped when the write-back stage is loaded (next edge, or the done pulse for shifts).
module tb_rf_alu_pipe;

  localparam logic [2:0] OpAdd = 3'b000, OpSub = 3'b010, OpSbb = 3'b011, OpAnd = 3'b100;
  localparam logic [2:0] OpShl = 3'b110, OpShr = 3'b111;
  localparam logic [2:0] WbAlu = 3'b000, WbMem = 3'b001, WbLhi = 3'b011, WbLli = 3'b100;
  localparam logic [2:0] WbXor = 3'b110;

  typedef struct packed {
    logic [2:0] ctrl;
    logic       src;
    logic [2:0] wbs;
    logic       we;
    logic [2:0] rd;
    logic [2:0] rn;
    logic [2:0] rm;
    logic [4:0] i5;
    logic [7:0] i8;
  } op_t;

  logic        CLK = 1'b0;
  logic        CLR = 1'b0;
  logic        issue = 1'b0;
  logic [2:0]  ALUctrl = '0;
  logic        ALUsrc = 1'b0;
  logic [2:0]  wb_sel = '0;
  logic        WE = 1'b0;
  logic [2:0]  RdAddr = '0, RnAddr = '0, RmAddr = '0;
  logic        S_Rn_or_Rd = 1'b0;
  logic [4:0]  imm5 = '0;
  logic [7:0]  imm8 = '0;
  logic [15:0] Memory_data = '0, PC_data = '0;
  logic [15:0] RD1, RD2, Result;
  logic        C, V, N, Z, busy, done;

  logic [19:0] exp_q [$];
  logic [19:0] got, want;
  int passed = 0;
  int total  = 0;

  rf_alu_pipe dut (
    .CLK(CLK), .CLR(CLR), .issue(issue), .ALUctrl(ALUctrl), .ALUsrc(ALUsrc),
    .wb_sel(wb_sel), .WE(WE), .RdAddr(RdAddr), .RnAddr(RnAddr), .RmAddr(RmAddr),
    .S_Rn_or_Rd(S_Rn_or_Rd), .imm5(imm5), .imm8(imm8), .Memory_data(Memory_data),
    .PC_data(PC_data), .RD1(RD1), .RD2(RD2), .Result(Result), .C(C), .V(V), .N(N),
    .Z(Z), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  function automatic op_t mk(input logic [2:0] ctrl, input logic src, input logic [2:0] wbs,
                             input logic [2:0] rd, input logic [2:0] rn, input logic [2:0] rm,
                             input logic [4:0] i5, input logic [7:0] i8);
    op_t o;
    o.ctrl = ctrl; o.src = src; o.wbs = wbs; o.we = 1'b1;
    o.rd = rd; o.rn = rn; o.rm = rm; o.i5 = i5; o.i8 = i8;
    return o;
  endfunction

  // Present one operation for a single accept edge, then sample 1 time unit later
  task automatic send(input op_t o);
    ALUctrl = o.ctrl; ALUsrc = o.src; wb_sel = o.wbs; WE = o.we;
    RdAddr = o.rd; RnAddr = o.rn; RmAddr = o.rm; imm5 = o.i5; imm8 = o.i8;
    issue = 1'b1;
    @(posedge CLK); #1;
    issue = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    RnAddr = 3'd0; RmAddr = 3'd7;
    #1;
    total++;
    if ({Result, N, Z, C, V, busy, done, RD1, RD2} !== 54'd0)
      $display("FAIL reset: got %h required 0", {Result, N, Z, C, V, busy, done, RD1, RD2});
    else passed++;
    @(negedge CLK); CLR = 1'b1;
  endtask

  task automatic test_load();
    @(posedge CLK); #1;
    for (int i = 0; i < 8; i++) begin
      Memory_data = 16'((i + 1) * 17);
      exp_q.push_back({16'((i + 1) * 17), 4'b0000});
      send(mk(OpAdd, 1'b0, WbMem, 3'(i), 3'd0, 3'd0, 5'd0, 8'd0));
      got = {Result, N, Z, C, V}; want = exp_q.pop_front(); total++;
      if (got !== want) $display("FAIL load[%0d]: got %h required %h", i, got, want);
      else passed++;
    end
    WE = 1'b0; S_Rn_or_Rd = 1'b0;
    for (int i = 0; i < 8; i++) begin
      RnAddr = 3'(i); RmAddr = 3'(7 - i);
      #1;
      total++;
      if (RD1 !== 16'((i + 1) * 17)) $display("FAIL rd1_read[%0d]: got %h required %h",
                                               i, RD1, 16'((i + 1) * 17));
      else passed++;
      total++;
      if (RD2 !== 16'((8 - i) * 17)) $display("FAIL rd2_read[%0d]: got %h required %h",
                                               i, RD2, 16'((8 - i) * 17));
      else passed++;
    end
    // Reset with a write still pending in the write-back stage
    @(posedge CLK); #1;
    Memory_data = 16'hBEEF;
    send(mk(OpAdd, 1'b0, WbMem, 3'd0, 3'd0, 3'd0, 5'd0, 8'd0));
    #2; CLR = 1'b0;
    for (int i = 0; i < 8; i++) begin
      RnAddr = 3'(i);
      #1;
      total++;
      if (RD1 !== 16'h0000) $display("FAIL clr_mid[%0d]: got %h required 0000", i, RD1);
      else passed++;
    end
    total++;
    if (Result !== 16'h0000) $display("FAIL clr_result: got %h required 0000", Result);
    else passed++;
    @(negedge CLK); CLR = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_forward();
    exp_q.push_back({16'h0078, 4'b0000});
    send(mk(OpAdd, 1'b0, WbLli, 3'd1, 3'd1, 3'd1, 5'd0, 8'h78));
    got = {Result, N, Z, C, V}; want = exp_q.pop_front(); total++;
    if (got !== want) $display("FAIL fwd_lli: got %h required %h", got, want); else passed++;
    total++;
    if (RD1 !== 16'h0078) $display("FAIL fwd_rd1: got %h required 0078", RD1); else passed++;
    exp_q.push_back({16'h00F0, 4'b0000});
    send(mk(OpAdd, 1'b0, WbAlu, 3'd2, 3'd1, 3'd1, 5'd0, 8'd0));
    got = {Result, N, Z, C, V}; want = exp_q.pop_front(); total++;
    if (got !== want) $display("FAIL fwd_add: got %h required %h", got, want); else passed++;
    RnAddr = 3'd2; RdAddr = 3'd1; S_Rn_or_Rd = 1'b1;
    @(posedge CLK); #1;
    total++;
    if ({RD1, RD2} !== {16'h00F0, 16'h0078})
      $display("FAIL fwd_commit: got %h required 00f00078", {RD1, RD2});
    else passed++;
    S_Rn_or_Rd = 1'b0;
  endtask

  task automatic test_flags();
    op_t ops [7];
    logic [19:0] exps [7];
    ops[0] = mk(OpSub, 1'b1, WbAlu, 3'd3, 3'd0, 3'd0, 5'd1, 8'd0);
    exps[0] = {16'hFFFF, 4'b1000};
    ops[1] = mk(OpAdd, 1'b0, WbLli, 3'd4, 3'd0, 3'd0, 5'd0, 8'h05);
    exps[1] = {16'h0005, 4'b1000};
    ops[2] = mk(OpSbb, 1'b1, WbAlu, 3'd4, 3'd4, 3'd0, 5'd2, 8'd0);
    exps[2] = {16'h0002, 4'b0010};
    ops[3] = mk(OpAdd, 1'b0, WbLli, 3'd5, 3'd0, 3'd0, 5'd0, 8'hFF);
    exps[3] = {16'h00FF, 4'b0010};
    ops[4] = mk(OpAdd, 1'b0, WbLhi, 3'd5, 3'd0, 3'd0, 5'd0, 8'h7F);
    exps[4] = {16'h7FFF, 4'b0010};
    ops[5] = mk(OpAdd, 1'b1, WbAlu, 3'd6, 3'd5, 3'd0, 5'd1, 8'd0);
    exps[5] = {16'h8000, 4'b1001};
    ops[6] = mk(OpAnd, 1'b0, WbAlu, 3'd6, 3'd6, 3'd0, 5'd0, 8'd0);
    exps[6] = {16'h0000, 4'b0101};
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(exps[i]);
      send(ops[i]);
      got = {Result, N, Z, C, V}; want = exp_q.pop_front(); total++;
      if (got !== want) $display("FAIL flags[%0d]: got %h required %h", i, got, want);
      else passed++;
    end
    exp_q.push_back({16'h7FFE, 4'b0001});
    send(mk(OpAdd, 1'b1, WbXor, 3'd7, 3'd5, 3'd0, 5'd1, 8'd0));
    got = {Result, N, Z, C, V}; want = exp_q.pop_front(); total++;
    if (got !== want) $display("FAIL flags_xor: got %h required %h", got, want); else passed++;
  endtask

  task automatic test_lhi_lli();
    op_t ops [3];
    logic [19:0] exps [3];
    ops[0] = mk(OpAdd, 1'b0, WbLli, 3'd3, 3'd0, 3'd0, 5'd0, 8'h34);
    exps[0] = {16'h0034, 4'b0001};
    ops[1] = mk(OpAdd, 1'b0, WbLhi, 3'd3, 3'd0, 3'd0, 5'd0, 8'h12);
    exps[1] = {16'h1234, 4'b0001};
    ops[2] = mk(OpAdd, 1'b0, WbLli, 3'd7, 3'd0, 3'd0, 5'd0, 8'hAB);
    exps[2] = {16'h00AB, 4'b0001};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(exps[i]);
      send(ops[i]);
      got = {Result, N, Z, C, V}; want = exp_q.pop_front(); total++;
      if (got !== want) $display("FAIL lhi_lli[%0d]: got %h required %h", i, got, want);
      else passed++;
    end
  endtask

  task automatic test_shift();
    op_t ops [3];
    logic [19:0] exps [3];
    int cycles [3];
    int nb;
    bit seen;
    exp_q.push_back({16'h0001, 4'b0001});
    send(mk(OpAdd, 1'b0, WbLli, 3'd4, 3'd0, 3'd0, 5'd0, 8'h01));
    void'(exp_q.pop_front());
    exp_q.push_back({16'h8001, 4'b0001});
    send(mk(OpAdd, 1'b0, WbLhi, 3'd4, 3'd0, 3'd0, 5'd0, 8'h80));
    got = {Result, N, Z, C, V}; want = exp_q.pop_front(); total++;
    if (got !== want) $display("FAIL shift_setup: got %h required %h", got, want);
    else passed++;
    // SHL 8001 by 1, then shift-by-0 of R3 in its done cycle, then SHR 00F0 by 4
    ops[0] = mk(OpShl, 1'b1, WbAlu, 3'd4, 3'd4, 3'd0, 5'd1, 8'd0);
    exps[0] = {16'h0002, 4'b0011}; cycles[0] = 1;
    ops[1] = mk(OpShl, 1'b1, WbAlu, 3'd3, 3'd3, 3'd0, 5'd0, 8'd0);
    exps[1] = {16'h1234, 4'b0011}; cycles[1] = 1;
    ops[2] = mk(OpShr, 1'b1, WbAlu, 3'd5, 3'd2, 3'd0, 5'd4, 8'd0);
    exps[2] = {16'h000F, 4'b0000}; cycles[2] = 4;
    for (int s = 0; s < 3; s++) begin
      exp_q.push_back(exps[s]);
      send(ops[s]);
      nb = 0; seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
        if (done) seen = 1'b1;
        else begin
          if (busy) nb++;
          if (s == 2 && k == 1) begin
            // Must be ignored: shifter busy
            wb_sel = WbLli; RdAddr = 3'd5; imm8 = 8'hEE; issue = 1'b1;
          end else issue = 1'b0;
          @(posedge CLK); #1;
        end
      end
      issue = 1'b0;
      total++;
      if (!seen) $display("FAIL shift_timeout[%0d]: done not seen, required within 40", s);
      else passed++;
      total++;
      if (nb !== cycles[s]) $display("FAIL shift_busy[%0d]: got %0d required %0d",
                                      s, nb, cycles[s]);
      else passed++;
      got = {Result, N, Z, C, V}; want = exp_q.pop_front(); total++;
      if (got !== want) $display("FAIL shift_res[%0d]: got %h required %h", s, got, want);
      else passed++;
      if (s == 1) begin
        // Dependent op issued in the done cycle reads R3 through forwarding
        exp_q.push_back({16'h1235, 4'b0000});
        send(mk(OpAdd, 1'b1, WbAlu, 3'd6, 3'd3, 3'd0, 5'd1, 8'd0));
        got = {Result, N, Z, C, V}; want = exp_q.pop_front(); total++;
        if (got !== want) $display("FAIL done_issue: got %h required %h", got, want);
        else passed++;
      end
    end
    @(posedge CLK); #1;
    RnAddr = 3'd5; RmAddr = 3'd6; RdAddr = 3'd4; S_Rn_or_Rd = 1'b1;
    #1;
    total++;
    if ({RD1, RD2} !== {16'h000F, 16'h0002})
      $display("FAIL shift_commit: got %h required 000f0002", {RD1, RD2});
    else passed++;
    S_Rn_or_Rd = 1'b0;
    #1;
    total++;
    if (RD2 !== 16'h1235) $display("FAIL r6_commit: got %h required 1235", RD2); else passed++;
  endtask

  task automatic test_back_to_back();
    @(posedge CLK); #1;
    exp_q.push_back({16'h0011, 4'b0000});
    exp_q.push_back({16'h0022, 4'b0000});
    exp_q.push_back({16'h0044, 4'b0000});
    send(mk(OpAdd, 1'b0, WbLli, 3'd1, 3'd0, 3'd0, 5'd0, 8'h11));
    for (int i = 0; i < 3; i++) begin
      got = {Result, N, Z, C, V}; want = exp_q.pop_front(); total++;
      if (got !== want) $display("FAIL b2b[%0d]: got %h required %h", i, got, want);
      else passed++;
      if (i == 0) send(mk(OpAdd, 1'b0, WbLli, 3'd1, 3'd0, 3'd0, 5'd0, 8'h22));
      if (i == 1) send(mk(OpAdd, 1'b0, WbAlu, 3'd2, 3'd1, 3'd1, 5'd0, 8'd0));
    end
    @(posedge CLK); #1;
    RnAddr = 3'd1; RmAddr = 3'd2;
    #1;
    total++;
    if ({RD1, RD2} !== {16'h0022, 16'h0044})
      $display("FAIL b2b_commit: got %h required 00220044", {RD1, RD2});
    else passed++;
  endtask

  task automatic test_clr_shift();
    bit pulsed;
    send(mk(OpShr, 1'b1, WbAlu, 3'd1, 3'd2, 3'd0, 5'd4, 8'd0));
    @(posedge CLK); #3;
    CLR = 1'b0;
    #1;
    total++;
    if ({busy, done} !== 2'b00) $display("FAIL clr_busy: got %b required 00", {busy, done});
    else passed++;
    @(negedge CLK); CLR = 1'b1;
    pulsed = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge CLK); #1;
      if (done) pulsed = 1'b1;
    end
    total++;
    if (pulsed) $display("FAIL clr_done: got pulse required none"); else passed++;
    RnAddr = 3'd1;
    #1;
    total++;
    if ({RD1, Result} !== 32'd0) $display("FAIL clr_dest: got %h required 0", {RD1, Result});
    else passed++;
  endtask

  initial begin
    test_reset();
    test_load();
    test_forward();
    test_flags();
    test_lhi_lli();
    test_shift();
    test_back_to_back();
    test_clr_shift();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
